stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: BCD mm:ss count chain driven by a prescaled tick,
// with a run/pause/lap/done state machine and a frozen-or-live display bus.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [2:0] min_l,
  output logic [3:0] min_r,
  output logic [2:0] sec_l,
  output logic [3:0] sec_r,
  output logic       running,
  output logic       frozen,
  output logic       done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [2:0]    cm_l, cs_l, cm_l_next, cs_l_next;
  logic [3:0]    cm_r, cs_r, cm_r_next, cs_r_next;
  logic          counting_c, tick_c, at_max_c, zero_c, inc_c, hold_disp_c;
  logic          running_next, frozen_next, done_next;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; within a state the highest-priority valid input wins
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_stop) state_next = RUN;
      RUN: begin
        if (start_stop)              state_next = PAUSE;
        else if (lap)                state_next = LAP;
        else if (tick_c && at_max_c) state_next = DONE;
      end
      LAP: begin
        if (start_stop)              state_next = PAUSE;
        else if (lap)                state_next = RUN;
        else if (tick_c && at_max_c) state_next = DONE;
      end
      PAUSE: begin
        if (clear)           state_next = IDLE;
        else if (start_stop) state_next = RUN;
      end
      DONE:  if (clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values and status flag decode
  always_comb begin
    counting_c   = (state == RUN) || (state == LAP);
    tick_c       = counting_c && (presc == PRESC_MAX);
    at_max_c     = (cm_l == 3'd5) && (cm_r == 4'd9) && (cs_l == 3'd5) && (cs_r == 4'd9);
    zero_c       = clear && ((state == PAUSE) || (state == DONE));
    inc_c        = tick_c && !at_max_c;
    hold_disp_c  = (state == LAP) && (state_next == LAP);
    running_next = (state_next == RUN) || (state_next == LAP);
    frozen_next  = (state_next == LAP);
    done_next    = (state_next == DONE);

    if (counting_c)          presc_next = tick_c ? '0 : presc + PW'(1);
    else if (state == PAUSE) presc_next = presc;
    else                     presc_next = '0;

    cm_l_next = cm_l;
    cm_r_next = cm_r;
    cs_l_next = cs_l;
    cs_r_next = cs_r;
    if (zero_c) begin
      cm_l_next = 3'd0;
      cm_r_next = 4'd0;
      cs_l_next = 3'd0;
      cs_r_next = 4'd0;
    end else if (inc_c) begin
      if (cs_r != 4'd9) begin
        cs_r_next = cs_r + 4'd1;
      end else begin
        cs_r_next = 4'd0;
        if (cs_l != 3'd5) begin
          cs_l_next = cs_l + 3'd1;
        end else begin
          cs_l_next = 3'd0;
          if (cm_r != 4'd9) begin
            cm_r_next = cm_r + 4'd1;
          end else begin
            cm_r_next = 4'd0;
            cm_l_next = cm_l + 3'd1;
          end
        end
      end
    end
  end

  // Prescaler, count chain, display latch and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      cm_l    <= 3'd0;
      cm_r    <= 4'd0;
      cs_l    <= 3'd0;
      cs_r    <= 4'd0;
      min_l   <= 3'd0;
      min_r   <= 4'd0;
      sec_l   <= 3'd0;
      sec_r   <= 4'd0;
      running <= 1'b0;
      frozen  <= 1'b0;
      done    <= 1'b0;
    end else begin
      presc   <= presc_next;
      cm_l    <= cm_l_next;
      cm_r    <= cm_r_next;
      cs_l    <= cs_l_next;
      cs_r    <= cs_r_next;
      running <= running_next;
      frozen  <= frozen_next;
      done    <= done_next;
      if (!hold_disp_c) begin
        min_l <= cm_l_next;
        min_r <= cm_r_next;
        sec_l <= cs_l_next;
        sec_r <= cs_r_next;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] min_l, sec_l;
  logic [3:0] min_r, sec_r;
  logic       running, frozen, done;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] obs;
  logic [16:0] exp;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .running(running), .frozen(frozen), .done(done)
  );

  always #5 clk = ~clk;

  // Display digits followed by {running, frozen, done}
  assign obs = {min_l, min_r, sec_l, sec_r, running, frozen, done};

  function automatic logic [16:0] pat(int mm, int ss, logic [2:0] flags);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), flags};
  endfunction

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
    reset = 1'b1;
    wait_cyc(3);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_count();
    do_reset();
    pulse_ss();
    checks++; exp = pat(0, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_start got=%h exp=%h", obs, exp); end
    wait_cyc(3);
    checks++; exp = pat(0, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_before_tick got=%h exp=%h", obs, exp); end
    wait_cyc(1);
    checks++; exp = pat(0, 1, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_first_tick got=%h exp=%h", obs, exp); end
    wait_cyc(32);
    checks++; exp = pat(0, 9, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_0009 got=%h exp=%h", obs, exp); end
    wait_cyc(4);
    checks++; exp = pat(0, 10, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_0010 got=%h exp=%h", obs, exp); end
    wait_cyc(196);
    checks++; exp = pat(0, 59, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_0059 got=%h exp=%h", obs, exp); end
    wait_cyc(4);
    checks++; exp = pat(1, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL count_0100 got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_lap();
    do_reset();
    pulse_ss();
    wait_cyc(20);
    checks++; exp = pat(0, 5, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL lap_pre got=%h exp=%h", obs, exp); end
    pulse_lap();
    checks++; exp = pat(0, 5, 3'b110);
    if (obs !== exp) begin failures++; $display("FAIL lap_enter got=%h exp=%h", obs, exp); end
    wait_cyc(12);
    checks++; exp = pat(0, 5, 3'b110);
    if (obs !== exp) begin failures++; $display("FAIL lap_hold got=%h exp=%h", obs, exp); end
    pulse_lap();
    checks++; exp = pat(0, 8, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL lap_release got=%h exp=%h", obs, exp); end
    wait_cyc(2);
    checks++; exp = pat(0, 9, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL lap_live got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_ss();
    wait_cyc(2);
    pulse_ss();
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL pause_enter got=%h exp=%h", obs, exp); end
    wait_cyc(20);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL pause_hold got=%h exp=%h", obs, exp); end
    pulse_ss();
    checks++; exp = pat(0, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL pause_resume got=%h exp=%h", obs, exp); end
    wait_cyc(1);
    checks++; exp = pat(0, 1, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL pause_phase got=%h exp=%h", obs, exp); end
    pulse_clear();
    checks++; exp = pat(0, 1, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL clear_in_run got=%h exp=%h", obs, exp); end
    pulse_ss();
    checks++; exp = pat(0, 1, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL pause_again got=%h exp=%h", obs, exp); end
    pulse_clear();
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL clear_in_pause got=%h exp=%h", obs, exp); end
    pulse_lap();
    wait_cyc(3);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL idle_ignores_lap got=%h exp=%h", obs, exp); end
    pulse_ss();
    wait_cyc(3);
    checks++; exp = pat(0, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL restart_phase got=%h exp=%h", obs, exp); end
    wait_cyc(1);
    checks++; exp = pat(0, 1, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL restart_tick got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_done();
    do_reset();
    pulse_ss();
    wait_cyc(14396);
    checks++; exp = pat(59, 59, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL done_reach_max got=%h exp=%h", obs, exp); end
    wait_cyc(3);
    checks++; exp = pat(59, 59, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL done_pre_tick got=%h exp=%h", obs, exp); end
    wait_cyc(1);
    checks++; exp = pat(59, 59, 3'b001);
    if (obs !== exp) begin failures++; $display("FAIL done_enter got=%h exp=%h", obs, exp); end
    wait_cyc(8);
    checks++; exp = pat(59, 59, 3'b001);
    if (obs !== exp) begin failures++; $display("FAIL done_saturate got=%h exp=%h", obs, exp); end
    pulse_ss();
    pulse_lap();
    wait_cyc(4);
    checks++; exp = pat(59, 59, 3'b001);
    if (obs !== exp) begin failures++; $display("FAIL done_ignores_buttons got=%h exp=%h", obs, exp); end
    pulse_clear();
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL done_clear got=%h exp=%h", obs, exp); end
    wait_cyc(4);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL done_clear_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_ss();
    wait_cyc(3);
    pulse_ss();
    checks++; exp = pat(0, 1, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL tick_with_pause got=%h exp=%h", obs, exp); end
    clear = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_stop = 1'b0;
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL clear_beats_ss got=%h exp=%h", obs, exp); end
    wait_cyc(8);
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL clear_beats_ss_idle got=%h exp=%h", obs, exp); end
    pulse_ss();
    start_stop = 1'b1; lap = 1'b1;
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0;
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL ss_beats_lap got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_ss();
    wait_cyc(9);
    checks++; exp = pat(0, 2, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL async_pre got=%h exp=%h", obs, exp); end
    #2 reset = 1'b0;
    #1;
    checks++; exp = pat(0, 0, 3'b000);
    if (obs !== exp) begin failures++; $display("FAIL async_immediate got=%h exp=%h", obs, exp); end
    @(negedge clk);
    reset = 1'b1;
    pulse_ss();
    wait_cyc(3);
    checks++; exp = pat(0, 0, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL async_fresh_phase got=%h exp=%h", obs, exp); end
    wait_cyc(1);
    checks++; exp = pat(0, 1, 3'b100);
    if (obs !== exp) begin failures++; $display("FAIL async_fresh_tick got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_lap();
    test_pause();
    test_done();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
